// File: rtl/ym_bus_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : ym_bus_sequencer
//  Description : Queues CPU writes to the YM2149 ports (FFFD/BFFD) in a small
//                FIFO and replays them onto the YM bus as SETUP/STROBE/HOLD
//                cycles. Drives TurboSound chip selects from FE/FF commands.
//  Revision    : 1.0 - initial release
// ============================================================================
module ym_bus_sequencer #(
  parameter int unsigned SETUP_CYC  = 1,
  parameter int unsigned STROBE_CYC = 3,
  parameter int unsigned HOLD_CYC   = 1
) (
  input  logic       cpu_clock,
  input  logic       reset,
  input  logic       req_valid,
  input  logic       req_type,
  input  logic [7:0] req_data,
  output logic       req_ready,
  output logic [7:0] ym_da,
  output logic       ym_da_oe,
  output logic       ym_bdir,
  output logic       ym_bc1,
  output logic       ym_cs0_n,
  output logic       ym_cs1_n,
  output logic       idle,
  output logic       ovf
);

  // Dwell reload values: the counter counts down to zero, so N cycles load N-1.
  localparam logic [2:0] c_setup_ld  = 3'(SETUP_CYC - 1);
  localparam logic [2:0] c_strobe_ld = 3'(STROBE_CYC - 1);
  localparam logic [2:0] c_hold_ld   = 3'(HOLD_CYC - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  dwell_q, dwell_d;
  logic [8:0]  mem_q [4];
  logic [8:0]  mem_d [4];
  logic [1:0]  wr_ptr_q, wr_ptr_d;
  logic [1:0]  rd_ptr_q, rd_ptr_d;
  logic [2:0]  count_q, count_d;
  logic        sel_q, sel_d;
  logic [7:0]  da_q, da_d;
  logic        type_q, type_d;
  logic        oe_q, oe_d;
  logic        bdir_q, bdir_d;
  logic        bc1_q, bc1_d;
  logic        ovf_q, ovf_d;

  logic        w_push;
  logic        w_pop;
  logic        w_empty;
  logic [8:0]  w_head;
  logic        w_head_is_cs;

  // Space is judged on the registered count only; a same-cycle pop does not help.
  assign req_ready    = (count_q < 3'd4);
  assign w_push       = req_valid & req_ready;
  assign w_empty      = (count_q == 3'd0);
  assign w_head       = mem_q[rd_ptr_q];
  // Address write of F8..FF is a TurboSound chip-select command, not a bus cycle.
  assign w_head_is_cs = ~w_head[8] & (w_head[7:3] == 5'b11111);

  // FIFO storage, pointers, occupancy and the sticky overflow flag.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q | (req_valid & ~req_ready);
    if (w_push) begin
      mem_d[wr_ptr_q] = {req_type, req_data};
      wr_ptr_d        = wr_ptr_q + 2'd1;
    end
    if (w_pop) begin
      rd_ptr_d = rd_ptr_q + 2'd1;
    end
    case ({w_push, w_pop})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase
  end

  // Bus-cycle FSM: next state, dwell counter, head latch and chip-select update.
  always_comb begin
    state_d = state_q;
    dwell_d = dwell_q;
    da_d    = da_q;
    type_d  = type_q;
    sel_d   = sel_q;
    w_pop   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop = 1'b1;
          if (w_head_is_cs) begin
            sel_d = ~w_head[0];
          end else begin
            state_d = ST_SETUP;
            dwell_d = c_setup_ld;
            da_d    = w_head[7:0];
            type_d  = w_head[8];
          end
        end
      end
      ST_SETUP: begin
        if (dwell_q == 3'd0) begin
          state_d = ST_STROBE;
          dwell_d = c_strobe_ld;
        end else begin
          dwell_d = dwell_q - 3'd1;
        end
      end
      ST_STROBE: begin
        if (dwell_q == 3'd0) begin
          state_d = ST_HOLD;
          dwell_d = c_hold_ld;
        end else begin
          dwell_d = dwell_q - 3'd1;
        end
      end
      ST_HOLD: begin
        if (dwell_q == 3'd0) begin
          state_d = ST_IDLE;
        end else begin
          dwell_d = dwell_q - 3'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Bus controls are registered from the next state so the pins are glitch-free.
  always_comb begin
    oe_d   = (state_d != ST_IDLE);
    bdir_d = (state_d == ST_STROBE);
    bc1_d  = (state_d == ST_STROBE) & ~type_d;
  end

  // State registers; reset drops the bus controls immediately and flushes the FIFO.
  always_ff @(posedge cpu_clock or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      dwell_q  <= 3'd0;
      for (int i = 0; i < 4; i++) mem_q[i] <= 9'd0;
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
      count_q  <= 3'd0;
      sel_q    <= 1'b0;
      da_q     <= 8'h00;
      type_q   <= 1'b0;
      oe_q     <= 1'b0;
      bdir_q   <= 1'b0;
      bc1_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      dwell_q  <= dwell_d;
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      sel_q    <= sel_d;
      da_q     <= da_d;
      type_q   <= type_d;
      oe_q     <= oe_d;
      bdir_q   <= bdir_d;
      bc1_q    <= bc1_d;
      ovf_q    <= ovf_d;
    end
  end

  assign ym_da    = da_q;
  assign ym_da_oe = oe_q;
  assign ym_bdir  = bdir_q;
  assign ym_bc1   = bc1_q;
  assign ym_cs0_n = sel_q;
  assign ym_cs1_n = ~sel_q;
  assign idle     = (state_q == ST_IDLE) & w_empty;
  assign ovf      = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_ym_bus_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ym_bus_sequencer
//  Description : Directed self-checking bench for ym_bus_sequencer; a second
//                instance runs with SETUP=2 / STROBE=1 / HOLD=3 timing.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ym_bus_sequencer;

  logic       clk;
  logic       reset_n;
  logic       req_valid;
  logic       req_type;
  logic [7:0] req_data;

  logic       a_ready, a_oe, a_bdir, a_bc1, a_cs0_n, a_cs1_n, a_idle, a_ovf;
  logic [7:0] a_da;
  logic       b_ready, b_oe, b_bdir, b_bc1, b_cs0_n, b_cs1_n, b_idle, b_ovf;
  logic [7:0] b_da;

  int n_cmp = 0;
  int n_err = 0;

  ym_bus_sequencer u_dut_a (
    .cpu_clock (clk),
    .reset     (reset_n),
    .req_valid (req_valid),
    .req_type  (req_type),
    .req_data  (req_data),
    .req_ready (a_ready),
    .ym_da     (a_da),
    .ym_da_oe  (a_oe),
    .ym_bdir   (a_bdir),
    .ym_bc1    (a_bc1),
    .ym_cs0_n  (a_cs0_n),
    .ym_cs1_n  (a_cs1_n),
    .idle      (a_idle),
    .ovf       (a_ovf)
  );

  ym_bus_sequencer #(
    .SETUP_CYC  (2),
    .STROBE_CYC (1),
    .HOLD_CYC   (3)
  ) u_dut_b (
    .cpu_clock (clk),
    .reset     (reset_n),
    .req_valid (req_valid),
    .req_type  (req_type),
    .req_data  (req_data),
    .req_ready (b_ready),
    .ym_da     (b_da),
    .ym_da_oe  (b_oe),
    .ym_bdir   (b_bdir),
    .ym_bc1    (b_bc1),
    .ym_cs0_n  (b_cs0_n),
    .ym_cs1_n  (b_cs1_n),
    .idle      (b_idle),
    .ovf       (b_ovf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case the directed sequence ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 ns past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic t, input logic [7:0] d);
    req_valid = 1'b1;
    req_type  = t;
    req_data  = d;
    step();
    req_valid = 1'b0;
  endtask

  // Step n cycles; bit j of each mask is the expected level after the j-th edge.
  task automatic run_expect(input string tag, input int n, input int which,
                            input logic [15:0] e_oe, input logic [15:0] e_bdir,
                            input logic [15:0] e_bc1, input logic [15:0] e_idle);
    for (int j = 0; j < n; j++) begin
      step();
      chk1({tag, "_oe"},   (which == 0) ? a_oe   : b_oe,   e_oe[j]);
      chk1({tag, "_bdir"}, (which == 0) ? a_bdir : b_bdir, e_bdir[j]);
      chk1({tag, "_bc1"},  (which == 0) ? a_bc1  : b_bc1,  e_bc1[j]);
      chk1({tag, "_idle"}, (which == 0) ? a_idle : b_idle, e_idle[j]);
    end
  endtask

  logic [7:0] burst [6];
  logic [5:0] exp_ready;
  int         found;
  int         hi_cnt;

  initial begin
    reset_n   = 1'b0;
    req_valid = 1'b0;
    req_type  = 1'b0;
    req_data  = 8'h00;
    burst[0] = 8'h11; burst[1] = 8'h22; burst[2] = 8'h33;
    burst[3] = 8'h44; burst[4] = 8'h55; burst[5] = 8'h66;
    exp_ready = 6'b011111;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk1("rst_idle", a_idle, 1'b1);
    chk1("rst_ready", a_ready, 1'b1);
    chk1("rst_ovf", a_ovf, 1'b0);
    chk8("rst_da", a_da, 8'h00);
    chk1("rst_oe", a_oe, 1'b0);
    chk1("rst_bdir", a_bdir, 1'b0);
    chk1("rst_bc1", a_bc1, 1'b0);
    chk1("rst_cs0n", a_cs0_n, 1'b0);
    chk1("rst_cs1n", a_cs1_n, 1'b1);
    reset_n = 1'b1;
    step();

    // Single address write 07
    push(1'b0, 8'h07);
    chk1("aw_pushed_oe", a_oe, 1'b0);
    chk1("aw_pushed_idle", a_idle, 1'b0);
    run_expect("aw", 6, 0, 16'b011111, 16'b001110, 16'b001110, 16'b100000);
    chk8("aw_da", a_da, 8'h07);

    // Address 07 then data 38 back to back
    push(1'b0, 8'h07);
    push(1'b1, 8'h38);
    chk1("ad_setup_oe", a_oe, 1'b1);
    chk1("ad_setup_bdir", a_bdir, 1'b0);
    chk8("ad_setup_da", a_da, 8'h07);
    run_expect("ad1", 4, 0, 16'b1111, 16'b0111, 16'b0111, 16'b0000);
    chk8("ad_hold_da", a_da, 8'h07);
    run_expect("ad2", 7, 0, 16'b0111110, 16'b0011100, 16'b0000000, 16'b1000000);
    chk8("ad_data_da", a_da, 8'h38);

    // Chip select FE, address 00, then FF
    push(1'b0, 8'hFE);
    push(1'b0, 8'h00);
    chk1("cs_fe_cs1n", a_cs1_n, 1'b0);
    chk1("cs_fe_cs0n", a_cs0_n, 1'b1);
    chk1("cs_fe_bdir", a_bdir, 1'b0);
    chk1("cs_fe_oe", a_oe, 1'b0);
    run_expect("cs_addr", 6, 0, 16'b011111, 16'b001110, 16'b001110, 16'b100000);
    chk8("cs_addr_da", a_da, 8'h00);
    chk1("cs_hold_cs1n", a_cs1_n, 1'b0);
    push(1'b0, 8'hFF);
    step();
    chk1("cs_ff_cs0n", a_cs0_n, 1'b0);
    chk1("cs_ff_cs1n", a_cs1_n, 1'b1);
    chk1("cs_ff_oe", a_oe, 1'b0);
    chk1("cs_ff_idle", a_idle, 1'b1);
    chk8("cs_ff_da", a_da, 8'h00);

    // Six consecutive data requests: sixth dropped
    for (int i = 0; i < 6; i++) begin
      chk1("ovf_ready", a_ready, exp_ready[i]);
      push(1'b1, burst[i]);
    end
    chk1("ovf_flag", a_ovf, 1'b1);
    chk1("ovf_hold_oe", a_oe, 1'b1);
    chk1("ovf_hold_bdir", a_bdir, 1'b0);
    chk8("ovf_first_da", a_da, 8'h11);
    for (int i = 1; i < 5; i++) begin
      found = 0;
      for (int c = 0; c < 20 && found == 0; c++) begin
        step();
        if (a_bdir === 1'b1) found = 1;
      end
      chk1("ovf_strobe_seen", (found == 1), 1'b1);
      chk8("ovf_order_da", a_da, burst[i]);
      chk1("ovf_strobe_bc1", a_bc1, 1'b0);
      for (int c = 0; c < 10 && a_bdir === 1'b1; c++) step();
    end
    hi_cnt = 0;
    for (int c = 0; c < 15; c++) begin
      step();
      if (a_bdir === 1'b1) hi_cnt++;
    end
    chk8("ovf_no_sixth", 8'(hi_cnt), 8'd0);
    chk1("ovf_sticky", a_ovf, 1'b1);
    chk1("ovf_drained_idle", a_idle, 1'b1);

    // Reset pulsed during STROBE with two entries queued
    push(1'b0, 8'hA0);
    push(1'b0, 8'hA1);
    push(1'b0, 8'hA2);
    chk1("rs_in_strobe", a_bdir, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    chk1("rs_bdir", a_bdir, 1'b0);
    chk1("rs_bc1", a_bc1, 1'b0);
    chk1("rs_oe", a_oe, 1'b0);
    chk1("rs_idle", a_idle, 1'b1);
    chk1("rs_ovf", a_ovf, 1'b0);
    chk1("rs_ready", a_ready, 1'b1);
    @(negedge clk);
    reset_n = 1'b1;
    hi_cnt = 0;
    for (int c = 0; c < 15; c++) begin
      step();
      if (a_bdir === 1'b1 || a_oe === 1'b1) hi_cnt++;
    end
    chk8("rs_no_strobe", 8'(hi_cnt), 8'd0);
    chk1("rs_idle_after", a_idle, 1'b1);
    chk1("rs_b_idle", b_idle, 1'b1);

    // Non-default timing instance: SETUP 2, STROBE 1, HOLD 3
    push(1'b0, 8'h5A);
    run_expect("tim", 7, 1, 16'b0111111, 16'b0000100, 16'b0000100, 16'b1000000);
    chk8("tim_da", b_da, 8'h5A);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ym_bus_sequencer.md
YM_BUS_SEQUENCER -- requirements
Module: ym_bus_sequencer

Interface
REQ-001 Parameter: SETUP_CYC, default 1, cycles the data bus is driven before the strobe (legal range 1..7).
REQ-002 Parameter: STROBE_CYC, default 3, cycles BDIR is asserted (legal range 1..7).
REQ-003 Parameter: HOLD_CYC, default 1, cycles the data bus is held after the strobe (legal range 1..7).
REQ-004 cpu_clock  input  1  sole clock; all state changes on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 req_valid  input  1  one-cycle request strobe from the port decoder.
REQ-007 req_type  input  1  0 = address/register-select write (port FFFD), 1 = data write (port BFFD).
REQ-008 req_data  input  8  CPU data byte for the request.
REQ-009 req_ready  output  1  high when the FIFO can accept a request.
REQ-010 ym_da  output  8  data/address byte to the YM bus.
REQ-011 ym_da_oe  output  1  YM bus output enable.
REQ-012 ym_bdir, ym_bc1  output  1 each  YM2149 bus control.
REQ-013 ym_cs0_n, ym_cs1_n  output  1 each  active-low chip selects (TurboSound).
REQ-014 idle  output  1  high when the FSM is in IDLE and the FIFO is empty.
REQ-015 ovf  output  1  sticky flag: a request was dropped.

Function
REQ-016 The block SHALL buffer requests in a 4-entry, 9-bit FIFO ({type, data}) with 3-bit occupancy count.
REQ-017 req_ready SHALL equal (count < 4), evaluated on the registered count; a pop in the same cycle does not free space.
REQ-018 On req_valid & req_ready the entry SHALL be pushed at that edge; on req_valid & ~req_ready it SHALL be dropped and ovf set to 1.
REQ-019 A head entry with type 0 and data[7:3] = 5'b11111 SHALL be a chip-select command: pop in IDLE, set sel = ~data[0] (FF -> chip 0, FE -> chip 1), stay in IDLE, no bus cycle.
REQ-020 The FSM SHALL have states IDLE, SETUP, STROBE, HOLD, with a 3-bit down-counter for dwell.
REQ-021 IDLE -> SETUP when the FIFO is non-empty and the head entry is not a chip-select command; the head SHALL be popped and latched into ym_da/type registers on that edge.
REQ-022 SETUP: ym_da_oe = 1, ym_bdir = 0, ym_bc1 = 0, for exactly SETUP_CYC cycles, then STROBE.
REQ-023 STROBE: ym_bdir = 1, ym_bc1 = ~type (address latch = 1, data write = 0), ym_da_oe = 1, for exactly STROBE_CYC cycles, then HOLD.
REQ-024 HOLD: ym_bdir = 0, ym_bc1 = 0, ym_da_oe = 1, ym_da unchanged, for exactly HOLD_CYC cycles, then IDLE.
REQ-025 In IDLE ym_da_oe, ym_bdir and ym_bc1 SHALL be 0; ym_da SHALL hold its last value.
REQ-026 Latency: a request pushed at edge k with empty FIFO and FSM idle SHALL enter SETUP at edge k+1; ym_bdir rises at edge k+1+SETUP_CYC.
REQ-027 Back-to-back transfers SHALL have at least one IDLE cycle between HOLD and the next SETUP.
REQ-028 ym_cs0_n SHALL equal sel and ym_cs1_n SHALL equal ~sel, registered; sel changes only in IDLE, never during a bus cycle.
REQ-029 Simultaneous push and pop SHALL leave count unchanged and preserve FIFO order.
REQ-030 FIFO pointers SHALL wrap modulo 4.

Reset
REQ-031 While reset = 0: FSM = IDLE, FIFO empty, count = 0, sel = 0 (cs0_n = 0, cs1_n = 1), ym_da = 8'h00, ym_da_oe/ym_bdir/ym_bc1 = 0, ovf = 0, req_ready = 1, idle = 1.
REQ-032 Reset asserted mid-transfer SHALL immediately deassert ym_bdir/ym_bc1/ym_da_oe and discard all queued entries.

Verification
REQ-033 Single address write 8'h07 (type 0), defaults -> SETUP 1 cycle, bdir = bc1 = 1 for 3 cycles, HOLD 1 cycle, ym_da = 07 throughout, idle after 6 cycles.
REQ-034 Address 8'h07 then data 8'h38 (type 1) -> second strobe has bdir = 1, bc1 = 0, ym_da = 38; one IDLE cycle between the transfers.
REQ-035 Write 8'hFE type 0, then address 8'h00 -> cs1_n = 0, cs0_n = 1 before the address SETUP; no bdir pulse for FE; then 8'hFF -> cs0_n = 0.
REQ-036 Six requests on consecutive cycles -> first five accepted (one popped), sixth dropped, ovf = 1 and remaining 1 until reset; accepted bytes appear in order.
REQ-037 Reset pulsed during STROBE with 2 entries queued -> bdir/bc1/oe = 0 asynchronously, idle = 1, no further strobes after release.
REQ-038 SETUP_CYC = 2, STROBE_CYC = 1, HOLD_CYC = 3 -> bdir high exactly 1 cycle, oe high exactly 6 cycles.
